// File: rtl/frame_checker.sv
// Receive-side frame checker: parses preamble/header/payload from a 16-bit stream,
// keeps good/bad frame counts and a payload byte checksum, and exposes them on an 8-bit Avalon slave.
module frame_checker #(
  parameter int STALL_PERIOD = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  input  logic        ingress_port_tvalid,
  output logic        ingress_port_tready
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] HEADER   = 3'd2;
  localparam logic [2:0] PAYLOAD  = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  localparam logic [15:0] PRE_WORD = 16'hAAAA;
  localparam logic [15:0] SFD_WORD = 16'hAAAB;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [2:0]           r_state;
  logic [15:0]          r_widx;
  logic [15:0][7:0]     r_hdr;
  logic [15:0][7:0]     r_vis;
  logic [31:0]          r_sumWork;
  logic [31:0]          r_sumVis;
  logic [CNT_WIDTH-1:0] r_goodCnt;
  logic [CNT_WIDTH-1:0] r_errCnt;
  logic                 r_lastErr;
  logic                 r_ready;

  logic [2:0]       w_stateNext;
  logic [15:0]      w_widxNext;
  logic [15:0][7:0] w_hdrNext;
  logic [31:0]      w_sumNext;
  logic             w_good;
  logic             w_bad;
  logic             w_acc;
  logic             w_stall;
  logic             w_clear;
  logic [15:0]      w_len;
  logic [16:0]      w_lastIdx;
  logic             w_atEnd;
  logic             w_hiValid;
  logic [2:0]       w_hdrSlot;
  logic [7:0]       w_rdMux;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^writedata;

  // Backpressure generator: a free-running counter knocks tready low once per period.
  if (STALL_PERIOD > 0) begin : g_stall
    logic [15:0] r_stallCnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_stallCnt <= 16'd0;
      else if (r_stallCnt == 16'(STALL_PERIOD - 1))
        r_stallCnt <= 16'd0;
      else
        r_stallCnt <= r_stallCnt + 16'd1;
    end
    assign w_stall = (r_stallCnt == 16'(STALL_PERIOD - 1));
  end else begin : g_noStall
    assign w_stall = 1'b0;
  end

  assign ingress_port_tready = r_ready && !w_stall;
  assign w_acc     = ingress_port_tvalid && ingress_port_tready;
  assign w_clear   = chipselect && write && (address == 8'd23);
  assign w_len     = {r_hdr[13], r_hdr[12]};
  assign w_lastIdx = 17'd11 + (({1'b0, w_len} + 17'd1) >> 1);
  assign w_atEnd   = ({1'b0, r_widx} == w_lastIdx);
  assign w_hiValid = !(w_atEnd && w_len[0]);
  // Header words 4..11 map onto byte slots 0..7 by their low three index bits.
  assign w_hdrSlot = r_widx[2:0] - 3'd4;

  always_comb begin
    w_stateNext = r_state;
    w_widxNext  = r_widx;
    w_hdrNext   = r_hdr;
    w_sumNext   = r_sumWork;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (w_acc) begin
      case (r_state)
        IDLE: begin
          w_sumNext = 32'd0;
          if (ingress_port_tdata != PRE_WORD || ingress_port_tlast) begin
            w_bad       = 1'b1;
            w_stateNext = ingress_port_tlast ? IDLE : DRAIN;
          end else begin
            w_stateNext = PREAMBLE;
            w_widxNext  = 16'd1;
          end
        end
        PREAMBLE: begin
          if (ingress_port_tdata != ((r_widx == 16'd3) ? SFD_WORD : PRE_WORD) ||
              ingress_port_tlast) begin
            w_bad       = 1'b1;
            w_stateNext = ingress_port_tlast ? IDLE : DRAIN;
          end else begin
            w_widxNext = r_widx + 16'd1;
            if (r_widx == 16'd3)
              w_stateNext = HEADER;
          end
        end
        HEADER: begin
          w_hdrNext[{w_hdrSlot, 1'b0}] = ingress_port_tdata[15:8];
          w_hdrNext[{w_hdrSlot, 1'b1}] = ingress_port_tdata[7:0];
          if (r_widx != 16'd11) begin
            if (ingress_port_tlast) begin
              w_bad       = 1'b1;
              w_stateNext = IDLE;
            end else begin
              w_widxNext = r_widx + 16'd1;
            end
          end else if (w_len == 16'd0) begin
            w_good      = ingress_port_tlast;
            w_bad       = !ingress_port_tlast;
            w_stateNext = ingress_port_tlast ? IDLE : DRAIN;
          end else if (ingress_port_tlast) begin
            w_bad       = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_stateNext = PAYLOAD;
            w_widxNext  = r_widx + 16'd1;
          end
        end
        PAYLOAD: begin
          w_sumNext = r_sumWork + {24'd0, ingress_port_tdata[7:0]} +
                      (w_hiValid ? {24'd0, ingress_port_tdata[15:8]} : 32'd0);
          if (w_atEnd) begin
            w_good      = ingress_port_tlast;
            w_bad       = !ingress_port_tlast;
            w_stateNext = ingress_port_tlast ? IDLE : DRAIN;
          end else if (ingress_port_tlast) begin
            w_bad       = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_widxNext = r_widx + 16'd1;
          end
        end
        DRAIN: begin
          if (ingress_port_tlast)
            w_stateNext = IDLE;
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_widx    <= 16'd0;
      r_hdr     <= '0;
      r_sumWork <= 32'd0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_widx    <= w_widxNext;
      r_hdr     <= w_hdrNext;
      r_sumWork <= w_sumNext;
      r_ready   <= 1'b1;
    end
  end

  // Visible results only move on a good frame; a software clear beats a same-cycle completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vis     <= '0;
      r_sumVis  <= 32'd0;
      r_goodCnt <= '0;
      r_errCnt  <= '0;
      r_lastErr <= 1'b0;
    end else begin
      if (w_good) begin
        r_vis    <= w_hdrNext;
        r_sumVis <= w_sumNext;
      end
      if (w_clear) begin
        r_goodCnt <= '0;
        r_errCnt  <= '0;
        r_lastErr <= 1'b0;
      end else if (w_good) begin
        r_goodCnt <= r_goodCnt + CNT_ONE;
        r_lastErr <= 1'b0;
      end else if (w_bad) begin
        r_errCnt  <= r_errCnt + CNT_ONE;
        r_lastErr <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdMux = 8'd0;
    if (address < 8'd16)
      w_rdMux = r_vis[address[3:0]];
    else begin
      case (address)
        8'd16:   w_rdMux = r_sumVis[7:0];
        8'd17:   w_rdMux = r_sumVis[15:8];
        8'd18:   w_rdMux = r_sumVis[23:16];
        8'd19:   w_rdMux = r_sumVis[31:24];
        8'd20:   w_rdMux = 8'(r_goodCnt);
        8'd21:   w_rdMux = 8'(r_errCnt);
        8'd22:   w_rdMux = {5'd0, r_state == DRAIN, r_lastErr, r_state != IDLE};
        default: w_rdMux = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      readdata <= 8'd0;
    else
      readdata <= (chipselect && read) ? w_rdMux : 8'd0;
  end

endmodule
